// File: rtl/irrig_display_scan_if.sv
// rtl/irrig_display_scan_if.sv - status inputs and display outputs of the irrigation display stage
interface irrig_display_scan_if;
  logic       H, M, L;
  logic       Bs, Vs, Ve;
  logic       Al, E;
  logic [3:0] seven_seg_digit;
  logic       segA, segB, segC, segD, segE, segF, segG;
  logic [4:0] column;
  logic [6:0] lines;

  modport master (
    output H, M, L, Bs, Vs, Ve, Al, E,
    input  seven_seg_digit, segA, segB, segC, segD, segE, segF, segG, column, lines
  );

  modport slave (
    input  H, M, L, Bs, Vs, Ve, Al, E,
    output seven_seg_digit, segA, segB, segC, segD, segE, segF, segG, column, lines
  );
endinterface

// File: rtl/irrig_display_scan.sv
// rtl/irrig_display_scan.sv - scans tank level and actuator status onto a 4-digit 7-seg and 5x7 matrix
module irrig_display_scan #(
  parameter int SCAN_DIV    = 50000,
  parameter int BLINK_TICKS = 250
) (
  input logic                  clock,
  input logic                  reset,
  irrig_display_scan_if.slave  io
);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [PW-1:0] PMAX = PW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BMAX = BW'(BLINK_TICKS - 1);

  // Segment order is {a,b,c,d,e,f,g}, active-low
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef struct packed {
    logic h, m, l, bs, vs, ve, al, e;
  } status_t;

  status_t       snap;
  logic [PW-1:0] pcnt;
  logic [BW-1:0] bcnt;
  logic [1:0]    dig;
  logic [2:0]    col;
  logic          phase;
  logic          tick;
  logic          blank;

  logic [3:0] dig_en_nxt, dig_en_q;
  logic [6:0] seg_nxt, seg_q;
  logic [4:0] col_sel_nxt, col_sel_q;
  logic [6:0] lines_nxt, lines_q;
  logic [6:0] level_seg;
  logic [6:0] level_bar;

  assign tick  = (pcnt == PMAX);
  assign blank = (snap.al | snap.e) & ~phase;

  always_ff @(posedge clock) begin
    if (reset) begin
      snap  <= '0;
      pcnt  <= '0;
      bcnt  <= '0;
      dig   <= '0;
      col   <= '0;
      phase <= 1'b1;
    end else begin
      snap <= '{h: io.H, m: io.M, l: io.L, bs: io.Bs, vs: io.Vs,
                ve: io.Ve, al: io.Al, e: io.E};
      pcnt <= tick ? '0 : pcnt + 1'b1;
      if (tick) begin
        dig <= dig + 1'b1;
        col <= (col == 3'd4) ? 3'd0 : col + 3'd1;
        // Blink phase free-runs so alarm onset never resynchronises it
        if (bcnt == BMAX) begin
          bcnt  <= '0;
          phase <= ~phase;
        end else begin
          bcnt <= bcnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    level_seg = SEG_0;
    if (snap.e)      level_seg = SEG_E;
    else if (snap.h) level_seg = SEG_3;
    else if (snap.m) level_seg = SEG_2;
    else if (snap.l) level_seg = SEG_1;

    // Bar height 7/5/2/0 rows lit from the bottom, E does not mask it
    level_bar = 7'h7F;
    if (snap.h)      level_bar = 7'b0000000;
    else if (snap.m) level_bar = 7'b1100000;
    else if (snap.l) level_bar = 7'b1111100;
  end

  always_comb begin
    dig_en_nxt  = ~(4'b0001 << dig);
    col_sel_nxt = 5'b00001 << col;
    seg_nxt     = SEG_BLANK;
    lines_nxt   = 7'h7F;

    case (dig)
      2'd0:    seg_nxt = snap.ve ? SEG_1 : SEG_0;
      2'd1:    seg_nxt = snap.vs ? SEG_1 : SEG_0;
      2'd2:    seg_nxt = snap.bs ? SEG_1 : SEG_0;
      default: seg_nxt = blank ? SEG_BLANK : level_seg;
    endcase

    case (col)
      3'd0:    lines_nxt = level_bar;
      3'd2:    lines_nxt = snap.bs ? 7'h00 : 7'h7F;
      3'd4:    lines_nxt = snap.vs ? 7'h00 : 7'h7F;
      default: lines_nxt = 7'h7F;
    endcase
    if (blank) lines_nxt = 7'h7F;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      dig_en_q  <= 4'hF;
      seg_q     <= SEG_BLANK;
      col_sel_q <= 5'b00000;
      lines_q   <= 7'h7F;
    end else begin
      dig_en_q  <= dig_en_nxt;
      seg_q     <= seg_nxt;
      col_sel_q <= col_sel_nxt;
      lines_q   <= lines_nxt;
    end
  end

  assign io.seven_seg_digit = dig_en_q;
  assign io.segA   = seg_q[6];
  assign io.segB   = seg_q[5];
  assign io.segC   = seg_q[4];
  assign io.segD   = seg_q[3];
  assign io.segE   = seg_q[2];
  assign io.segF   = seg_q[1];
  assign io.segG   = seg_q[0];
  assign io.column = col_sel_q;
  assign io.lines  = lines_q;
endmodule
